// File: rtl/sram_ctrl_pkg.sv
// Shared sizes and helpers for the 1RW+1R OpenRAM initiator-side controller.
package sram_ctrl_pkg;

  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_WMASKS   = DATA_WIDTH / 8;
  localparam int RSP_DEPTH    = 3;
  localparam int READ_LATENCY = 2;

  // Circular pointer advance over the RSP_DEPTH response slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(RSP_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/sram_rd_port.sv
// One read return path: in-flight tracking, capture into a 3-entry response FIFO,
// and the credit counter that throttles request acceptance.
module sram_rd_port #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_accept,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_ready
);
  import sram_ctrl_pkg::*;

  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_d [RSP_DEPTH];
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [1:0]              occ_q, occ_d;
  logic [1:0]              count_q, count_d;
  logic                    ready_q, ready_d;
  logic                    push, pop;

  // The last in-flight stage lines up with macro dout settling; capture it straight into the FIFO.
  assign push      = inflight_q[READ_LATENCY-1];
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = (occ_q != 2'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign req_ready = ready_q;

  always_comb begin
    inflight_d = {inflight_q[READ_LATENCY-2:0], rd_accept};
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sram_dout;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    case ({rd_accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Credits cover in-flight reads plus queued data, so the FIFO can never overflow.
    ready_d = (count_d < 2'(RSP_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      count_q    <= 2'd0;
      ready_q    <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Initiator-side controller for the 256x32 1RW+1R OpenRAM macro with registered pins.
// Define SRAM_CTRL_HAZARD_EN to stall port-1 reads colliding with a same-cycle port-0 write.
module sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  import sram_ctrl_pkg::*;

  logic                  rd0_ready, rd1_ready;
  logic                  acc0, acc1, rd0_accept;
  logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  assign req0_ready = rd0_ready;
  assign acc0       = req0_valid & req0_ready;
  assign rd0_accept = acc0 & ~req0_we;
  assign acc1       = req1_valid & req1_ready;

`ifdef SRAM_CTRL_HAZARD_EN
  logic hazard;
  // Holding the colliding port-1 read one cycle lets it see the written data.
  assign hazard     = acc0 & req0_we & req1_valid & (req0_addr == req1_addr);
  assign req1_ready = rd1_ready & ~hazard;
`else
  assign req1_ready = rd1_ready;
`endif

  always_comb begin
    csb0_d   = ~acc0;
    web0_d   = web0_q;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    csb1_d   = ~acc1;
    addr1_d  = addr1_q;
    if (acc0) begin
      web0_d  = ~req0_we;
      addr0_d = req0_addr;
      if (req0_we) begin
        wmask0_d = req0_wmask;
        din0_d   = req0_wdata;
      end
    end
    if (acc1) addr1_d = req1_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      csb1_q   <= 1'b1;
      addr1_q  <= '0;
    end else begin
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      csb1_q   <= csb1_d;
      addr1_q  <= addr1_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;

  sram_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd0 (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (rd0_accept),
    .sram_dout (sram_dout0),
    .req_ready (rd0_ready),
    .rsp_valid (rsp0_valid),
    .rsp_rdata (rsp0_rdata),
    .rsp_ready (rsp0_ready)
  );

  sram_rd_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd1 (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (acc1),
    .sram_dout (sram_dout1),
    .req_ready (rd1_ready),
    .rsp_valid (rsp1_valid),
    .rsp_ready (rsp1_ready),
    .rsp_rdata (rsp1_rdata)
  );

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Self-checking bench for sram_1rw1r_ctrl with a behavioural 1RW+1R macro and per-port scoreboards.
module tb_sram_1rw1r_ctrl;

  typedef struct {
    logic [31:0] data;
    bit          check;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_wmask;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_addr;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  int checks = 0;
  int errors = 0;
  exp_t exp0[$];
  exp_t exp1[$];
  logic [31:0] ref_mem  [256] = '{default: 32'h0};
  logic [31:0] sram_mem [256] = '{default: 32'h0};

  always #5 clk = ~clk;

  sram_1rw1r_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Macro model: pins sampled on posedge, read data appears on the following negedge.
  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic [7:0] ra0 = 8'h0, ra1 = 8'h0;
  initial begin
    sram_dout0 = 32'h0;
    sram_dout1 = 32'h0;
  end
  always @(posedge clk) begin
    pend0 <= 1'b0;
    pend1 <= 1'b0;
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        pend0 <= 1'b1;
        ra0   <= sram_addr0;
      end
    end
    if (!sram_csb1) begin
      pend1 <= 1'b1;
      ra1   <= sram_addr1;
    end
  end
  always @(negedge clk) begin
    if (pend0) sram_dout0 <= sram_mem[ra0];
    if (pend1) sram_dout1 <= sram_mem[ra1];
  end

  // Scoreboard: expectations pushed on accepted reads, popped on response handshakes.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] upd;
    if (!reset) begin
      if (rsp0_valid && rsp0_ready) begin
        checks++;
        assert (exp0.size() != 0) else begin
          errors++;
          $error("[TB] FAIL rsp0_unexpected observed=%h expected=none", rsp0_rdata);
        end
        if (exp0.size() != 0) begin
          e = exp0.pop_front();
          if (e.check) begin
            checks++;
            assert (rsp0_rdata === e.data) else begin
              errors++;
              $error("[TB] FAIL rsp0_data observed=%h expected=%h", rsp0_rdata, e.data);
            end
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        checks++;
        assert (exp1.size() != 0) else begin
          errors++;
          $error("[TB] FAIL rsp1_unexpected observed=%h expected=none", rsp1_rdata);
        end
        if (exp1.size() != 0) begin
          e = exp1.pop_front();
          if (e.check) begin
            checks++;
            assert (rsp1_rdata === e.data) else begin
              errors++;
              $error("[TB] FAIL rsp1_data observed=%h expected=%h", rsp1_rdata, e.data);
            end
          end
        end
      end
      if (req0_valid && req0_ready && !req0_we) exp0.push_back('{ref_mem[req0_addr], 1'b1});
      if (req1_valid && req1_ready) begin
        if (req0_valid && req0_ready && req0_we && req0_addr == req1_addr)
          exp1.push_back('{32'h0, 1'b0});
        else
          exp1.push_back('{ref_mem[req1_addr], 1'b1});
      end
      if (req0_valid && req0_ready && req0_we) begin
        upd = ref_mem[req0_addr];
        for (int b = 0; b < 4; b++)
          if (req0_wmask[b]) upd[8*b +: 8] = req0_wdata[8*b +: 8];
        ref_mem[req0_addr] = upd;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [7:0] addr,
                                input logic [31:0] data, input logic [3:0] mask);
    req0_valid = 1'b1;
    req0_we    = we;
    req0_addr  = addr;
    req0_wdata = data;
    req0_wmask = mask;
    tick();
    req0_valid = 1'b0;
    req0_we    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || rsp0_valid || rsp1_valid) && cyc < 30) begin
      tick();
      cyc++;
    end
    check_output(tag, 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic rdy;
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h0; req0_wdata = 32'h0; req0_wmask = 4'h0;
    req1_valid = 1'b0; req1_addr = 8'h0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #12;
    check_output("rst_csb0",    32'(sram_csb0),   32'd1);
    check_output("rst_csb1",    32'(sram_csb1),   32'd1);
    check_output("rst_web0",    32'(sram_web0),   32'd1);
    check_output("rst_wmask0",  32'(sram_wmask0), 32'd0);
    check_output("rst_addr0",   32'(sram_addr0),  32'd0);
    check_output("rst_addr1",   32'(sram_addr1),  32'd0);
    check_output("rst_din0",    sram_din0,        32'd0);
    check_output("rst_rsp0v",   32'(rsp0_valid),  32'd0);
    check_output("rst_rsp1v",   32'(rsp1_valid),  32'd0);
    check_output("rst_rdata0",  rsp0_rdata,       32'd0);
    check_output("rst_rdata1",  rsp1_rdata,       32'd0);
    check_output("rst_req0rdy", 32'(req0_ready),  32'd1);
    check_output("rst_req1rdy", 32'(req1_ready),  32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Full write then read on consecutive accepts, with latency checks.
    apply_stimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    check_output("wr_csb0",  32'(sram_csb0),   32'd0);
    check_output("wr_web0",  32'(sram_web0),   32'd0);
    check_output("wr_wmask", 32'(sram_wmask0), 32'hF);
    check_output("wr_addr0", 32'(sram_addr0),  32'h10);
    check_output("wr_din0",  sram_din0,        32'hDEADBEEF);
    apply_stimulus(1'b0, 8'h10, 32'h0, 4'h0);
    check_output("rd_web0",  32'(sram_web0),   32'd1);
    check_output("lat_t0",   32'(rsp0_valid),  32'd0);
    tick();
    check_output("lat_t1",   32'(rsp0_valid),  32'd0);
    tick();
    check_output("lat_t2",   32'(rsp0_valid),  32'd1);
    check_output("lat_data", rsp0_rdata,       32'hDEADBEEF);
    drain("drain_basic");

    // Byte-masked merge.
    apply_stimulus(1'b1, 8'h20, 32'h11223344, 4'hF);
    apply_stimulus(1'b1, 8'h20, 32'hAABBCCDD, 4'h5);
    apply_stimulus(1'b0, 8'h20, 32'h0, 4'h0);
    tick();
    tick();
    check_output("mask_data", rsp0_rdata, 32'h11BB33DD);
    drain("drain_mask");

    // Empty mask is issued unchanged and leaves memory alone.
    apply_stimulus(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0);
    check_output("zmask_wmask", 32'(sram_wmask0), 32'h0);
    check_output("zmask_web0",  32'(sram_web0),   32'd0);
    apply_stimulus(1'b0, 8'h10, 32'h0, 4'h0);
    drain("drain_zmask");

    // Port-1 backpressure: five offered reads, only three credits.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'h30 + i), 32'hC0DE0000 + i, 4'hF);
    rsp1_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      req1_valid = 1'b1;
      req1_addr  = 8'(8'h30 + n);
      rdy = req1_ready;
      tick();
      if (rdy) n++;
    end
    check_output("bp_accepted", 32'(n),          32'd3);
    check_output("bp_ready",    32'(req1_ready), 32'd0);
    check_output("bp_valid",    32'(rsp1_valid), 32'd1);
    check_output("bp_head",     rsp1_rdata,      32'hC0DE0000);
    rsp1_ready = 1'b1;
    for (int c = 0; c < 20 && n < 5; c++) begin
      req1_addr = 8'(8'h30 + n);
      rdy = req1_ready;
      tick();
      if (rdy) n++;
    end
    req1_valid = 1'b0;
    check_output("bp_total", 32'(n), 32'd5);
    drain("drain_bp");

    // Same-cycle port-0 write and port-1 read to one address.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h07; req0_wdata = 32'h55; req0_wmask = 4'hF;
    req1_valid = 1'b1; req1_addr = 8'h07;
    #1;
`ifdef SRAM_CTRL_HAZARD_EN
    check_output("haz_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req0_we = 1'b0;
    #1;
    check_output("haz_retry_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    check_output("haz_data", rsp1_rdata, 32'h55);
`else
    check_output("coll_ready", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req0_we = 1'b0;
    req1_valid = 1'b0;
`endif
    drain("drain_coll");

    // Reset with two reads in flight.
    apply_stimulus(1'b0, 8'h10, 32'h0, 4'h0);
    apply_stimulus(1'b0, 8'h20, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    check_output("rst_mid_csb0", 32'(sram_csb0), 32'd1);
    exp0.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_output("post_rst_rsp0v",   32'(rsp0_valid), 32'd0);
      check_output("post_rst_req0rdy", 32'(req0_ready), 32'd1);
      tick();
    end

    // Idle cycles keep both chip selects deasserted.
    for (int c = 0; c < 4; c++) begin
      check_output("idle_csb0", 32'(sram_csb0), 32'd1);
      check_output("idle_csb1", 32'(sram_csb1), 32'd1);
      tick();
    end
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
